// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the banked LC-3 SPRAM memory.
// Used by lc3_spram_bank and lc3_banked_mem (optional macro LC3_MEM_CLEAR_ON_RESET_EN).
package lc3_mem_pkg;

   localparam int SPRAM_AW = 14;
   localparam int SPRAM_DW = 16;

   typedef enum logic [1:0] {
      RESET = 2'd0,
      CLEAR = 2'd1,
      READY = 2'd2
   } mem_state_t;

   // Bank-select width; at least one bit so a 1-bank build still has a legal vector.
   function automatic int bank_sel_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lc3_spram_bank.sv
// One 16K x 16 SPRAM bank: the iCE40 SB_SPRAM256KA primitive for synthesis,
// an equivalent registered-read array model everywhere else.
module lc3_spram_bank
   import lc3_mem_pkg::*;
(
   input  logic                clk,
   input  logic                cs,
   input  logic                we,
   input  logic [SPRAM_AW-1:0] addr,
   input  logic [SPRAM_DW-1:0] wdata,
   output logic [SPRAM_DW-1:0] rdata
);

`ifdef SYNTHESIS
   SB_SPRAM256KA u_spram (
      .ADDRESS    (addr),
      .DATAIN     (wdata),
      .MASKWREN   (4'b1111),
      .WREN       (we),
      .CHIPSELECT (cs),
      .CLOCK      (clk),
      .STANDBY    (1'b0),
      .SLEEP      (1'b0),
      .POWEROFF   (1'b1),
      .DATAOUT    (rdata)
   );
`else
   // DATAOUT only updates on a selected read, matching the primitive's behaviour.
   logic [SPRAM_DW-1:0] mem [0:(1<<SPRAM_AW)-1];

   always_ff @(posedge clk) begin
      if (cs) begin
         if (we) mem[addr] <= wdata;
         else    rdata     <= mem[addr];
      end
   end
`endif

endmodule

// File: rtl/lc3_banked_mem.sv
// LC-3 main memory spread over NUM_BANKS SPRAM banks with a valid/ready port and 1-cycle reads.
// Define LC3_MEM_CLEAR_ON_RESET_EN to zero-fill every bank after each reset before init_done.
module lc3_banked_mem
   import lc3_mem_pkg::*;
#(
   parameter int NUM_BANKS = 4,
   parameter int BANK_AW   = 14,
   parameter int DW        = 16
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  req_valid,
   output logic                                  req_ready,
   input  logic                                  req_we,
   input  logic [BANK_AW+$clog2(NUM_BANKS)-1:0]  req_addr,
   input  logic [DW-1:0]                         req_wdata,
   output logic                                  rsp_valid,
   output logic [DW-1:0]                         rsp_rdata,
   output logic                                  init_done
);

   localparam int SW = bank_sel_w(NUM_BANKS);
   localparam int AW = BANK_AW + $clog2(NUM_BANKS);

   mem_state_t state, next_state;

   logic [SW-1:0]                 bank;
   logic                          accept;
   logic                          rd_accept;
   logic                          clearing;
   logic [NUM_BANKS-1:0]          cs;
   logic                          bank_we;
   logic [BANK_AW-1:0]            bank_addr;
   logic [DW-1:0]                 bank_wdata;
   logic [NUM_BANKS-1:0][DW-1:0]  dout;
   logic [SW-1:0]                 sel_q;
   logic [DW-1:0]                 hold_q;

   generate
      if (NUM_BANKS == 1) begin : g_one_bank
         assign bank = '0;
      end else begin : g_multi_bank
         assign bank = req_addr[AW-1:BANK_AW];
      end
   endgenerate

   assign req_ready = (state == READY);
   assign init_done = (state == READY);
   assign accept    = req_valid && req_ready;
   assign rd_accept = accept && !req_we;

`ifdef LC3_MEM_CLEAR_ON_RESET_EN
   logic [BANK_AW-1:0] clr_addr;

   assign clearing = (state == CLEAR);

   // Wraps back to 0 on the last write, so a later reset restarts cleanly.
   always_ff @(posedge clk) begin
      if (!rst_n)        clr_addr <= '0;
      else if (clearing) clr_addr <= clr_addr + BANK_AW'(1);
   end
`else
   assign clearing = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= RESET;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         RESET: begin
`ifdef LC3_MEM_CLEAR_ON_RESET_EN
            next_state = CLEAR;
`else
            next_state = READY;
`endif
         end
         CLEAR: begin
`ifdef LC3_MEM_CLEAR_ON_RESET_EN
            if (clr_addr == '1) next_state = READY;
`else
            next_state = READY;
`endif
         end
         READY:   next_state = READY;
         default: next_state = RESET;
      endcase
   end

   // Clear broadcasts a zero write to every bank; otherwise only the addressed bank is selected.
   always_comb begin
      cs         = '0;
      bank_we    = req_we;
      bank_addr  = req_addr[BANK_AW-1:0];
      bank_wdata = req_wdata;
      if (clearing) begin
         cs         = '1;
         bank_we    = 1'b1;
         bank_wdata = '0;
`ifdef LC3_MEM_CLEAR_ON_RESET_EN
         bank_addr  = clr_addr;
`endif
      end else begin
         for (int i = 0; i < NUM_BANKS; i++)
            cs[i] = accept && (bank == SW'(i));
      end
   end

   generate
      for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
         lc3_spram_bank u_bank (
            .clk   (clk),
            .cs    (cs[i]),
            .we    (bank_we),
            .addr  (bank_addr),
            .wdata (bank_wdata),
            .rdata (dout[i])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         sel_q     <= '0;
         hold_q    <= '0;
      end else begin
         rsp_valid <= rd_accept;
         if (rd_accept) sel_q  <= bank;
         if (rsp_valid) hold_q <= dout[sel_q];
      end
   end

   // Live bank output during the response cycle, last response otherwise.
   assign rsp_rdata = rsp_valid ? dout[sel_q] : hold_q;

endmodule

// File: tb/tb_lc3_banked_mem.sv
// Self-checking bench for lc3_banked_mem: directed scenarios plus a randomized run against
// an address-indexed reference memory; clear-on-reset scenarios when the macro is defined.
module tb_lc3_banked_mem;

   localparam int NB  = 4;
   localparam int BAW = 14;
   localparam int DW  = 16;
   localparam int AW  = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          init_done;

   int checks   = 0;
   int failures = 0;

   logic [15:0] ref_mem [int];
   logic [15:0] last_rsp = 16'h0000;

   lc3_banked_mem #(.NUM_BANKS(NB), .BANK_AW(BAW), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   // Outputs are sampled 1ns after the rising edge; inputs change at the same point.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic [15:0] a, input logic [15:0] d);
      req_valid = v;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      if (v && we) ref_mem[int'(a)] = d;
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 16'h0, 16'h0);
      repeat (3) tick();
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%0b want=0", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b want=0", rsp_valid); end
      checks++; if (rsp_rdata !== 16'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h want=0000", rsp_rdata); end
      checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%0b want=0", init_done); end
      rst_n = 1'b1;
`ifdef LC3_MEM_CLEAR_ON_RESET_EN
      // One edge leaves RESET, then 2^14 clear writes precede READY.
      n = 0;
      do begin tick(); n++; end while (!init_done && n < 20000);
      checks++; if (n !== 16385) begin failures++; $display("FAIL clear_duration got=%0d want=16385", n); end
      ref_mem.delete();
      ref_mem[0] = 16'h0; ref_mem[16'h7FFF] = 16'h0; ref_mem[16'hFFFF] = 16'h0;
`else
      n = 0;
      checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL pre_edge_init_done got=%0b want=0", init_done); end
      tick();
      checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL release_init_done got=%0b want=1", init_done); end
`endif
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL release_req_ready got=%0b want=1", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL release_rsp_valid got=%0b want=0", rsp_valid); end
`ifdef LC3_MEM_CLEAR_ON_RESET_EN
      drive(1'b1, 1'b0, 16'h0000, 16'h0); tick();
      checks++; if (rsp_rdata !== 16'h0) begin failures++; $display("FAIL clear_rd_0000 got=%h want=0000", rsp_rdata); end
      drive(1'b1, 1'b0, 16'h7FFF, 16'h0); tick();
      checks++; if (rsp_rdata !== 16'h0) begin failures++; $display("FAIL clear_rd_7fff got=%h want=0000", rsp_rdata); end
      drive(1'b1, 1'b0, 16'hFFFF, 16'h0); tick();
      checks++; if (rsp_rdata !== 16'h0) begin failures++; $display("FAIL clear_rd_ffff got=%h want=0000", rsp_rdata); end
      drive(1'b0, 1'b0, 16'h0, 16'h0); tick();
`endif
      last_rsp = 16'h0;
   endtask

   task automatic test_bank_isolation();
      drive(1'b1, 1'b1, 16'h0005, 16'h1234); tick();
      drive(1'b1, 1'b1, 16'hC005, 16'hABCD); tick();
      drive(1'b1, 1'b0, 16'h0005, 16'h0);    tick();
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL iso_valid0 got=%0b want=1", rsp_valid); end
      checks++; if (rsp_rdata !== 16'h1234) begin failures++; $display("FAIL iso_data0 got=%h want=1234", rsp_rdata); end
      drive(1'b1, 1'b0, 16'hC005, 16'h0);    tick();
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL iso_valid1 got=%0b want=1", rsp_valid); end
      checks++; if (rsp_rdata !== 16'hABCD) begin failures++; $display("FAIL iso_data1 got=%h want=abcd", rsp_rdata); end
      drive(1'b0, 1'b0, 16'h0, 16'h0); tick();
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL iso_idle_valid got=%0b want=0", rsp_valid); end
      checks++; if (rsp_rdata !== 16'hABCD) begin failures++; $display("FAIL iso_hold got=%h want=abcd", rsp_rdata); end
      last_rsp = 16'hABCD;
   endtask

   task automatic test_pipelined();
      logic [15:0] addrs [4];
      logic [15:0] datas [4];
      addrs = '{16'h0010, 16'h4010, 16'h8010, 16'hC010};
      datas = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, addrs[i], datas[i]); tick();
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, addrs[i], 16'h0); tick();
         checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL pipe_valid%0d got=%0b want=1", i, rsp_valid); end
         checks++; if (rsp_rdata !== datas[i]) begin failures++; $display("FAIL pipe_data%0d got=%h want=%h", i, rsp_rdata, datas[i]); end
      end
      drive(1'b0, 1'b0, 16'h0, 16'h0); tick();
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL pipe_tail_valid got=%0b want=0", rsp_valid); end
      last_rsp = 16'h4444;
   endtask

   task automatic test_read_after_write();
      drive(1'b1, 1'b1, 16'h2000, 16'h5A5A); tick();
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL raw_wr_valid got=%0b want=0", rsp_valid); end
      checks++; if (rsp_rdata !== last_rsp) begin failures++; $display("FAIL raw_wr_hold got=%h want=%h", rsp_rdata, last_rsp); end
      drive(1'b1, 1'b0, 16'h2000, 16'h0); tick();
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL raw_rd_valid got=%0b want=1", rsp_valid); end
      checks++; if (rsp_rdata !== 16'h5A5A) begin failures++; $display("FAIL raw_rd_data got=%h want=5a5a", rsp_rdata); end
      last_rsp = 16'h5A5A;
      drive(1'b0, 1'b0, 16'h0, 16'h0); tick();
   endtask

   task automatic test_random();
      logic [15:0] wq[$];
      logic [15:0] a, d, exp_d;
      logic        exp_v;
      int          r;
      foreach (ref_mem[k]) wq.push_back(16'(k));
      for (int it = 0; it < 400; it++) begin
         r = int'($urandom_range(0, 2));
         exp_v = 1'b0;
         exp_d = last_rsp;
         if (r == 0 || wq.size() == 0) begin
            a = 16'($urandom); d = 16'($urandom);
            drive(1'b1, 1'b1, a, d);
            wq.push_back(a);
         end else if (r == 1) begin
            a = wq[$urandom_range(0, wq.size() - 1)];
            drive(1'b1, 1'b0, a, 16'($urandom));
            exp_v = 1'b1;
            exp_d = ref_mem[int'(a)];
         end else begin
            drive(1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
         end
         tick();
         checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rnd_ready it=%0d got=%0b want=1", it, req_ready); end
         checks++; if (rsp_valid !== exp_v) begin failures++; $display("FAIL rnd_valid it=%0d got=%0b want=%0b", it, rsp_valid, exp_v); end
         checks++; if (rsp_rdata !== exp_d) begin failures++; $display("FAIL rnd_data it=%0d got=%h want=%h", it, rsp_rdata, exp_d); end
         last_rsp = exp_d;
      end
      drive(1'b0, 1'b0, 16'h0, 16'h0); tick();
   endtask

   task automatic test_reset_pending();
      int n;
      drive(1'b1, 1'b0, 16'h2000, 16'h0);
      rst_n = 1'b0;
      tick();
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstpend_valid got=%0b want=0", rsp_valid); end
      checks++; if (rsp_rdata !== 16'h0) begin failures++; $display("FAIL rstpend_data got=%h want=0000", rsp_rdata); end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rstpend_ready got=%0b want=0", req_ready); end
      drive(1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      rst_n = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!init_done && n < 20000);
      checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL rstpend_init got=%0b want=1 after %0d", init_done, n); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstpend_post_valid got=%0b want=0", rsp_valid); end
      last_rsp = 16'h0;
   endtask

`ifdef LC3_MEM_CLEAR_ON_RESET_EN
   task automatic test_clear_requests();
      int n;
      rst_n = 1'b0; tick(); tick();
      rst_n = 1'b1;
      // Held write attempt while clearing; must not land and must not be queued.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0001; req_wdata = 16'hFFFF;
      n = 0;
      do begin
         tick(); n++;
         if (n == 10) begin
            checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL clr_ready got=%0b want=0", req_ready); end
         end
         if (n == 100) begin req_valid = 1'b0; req_we = 1'b0; end
         if (n == 5000) begin
            rst_n = 1'b0; tick(); rst_n = 1'b1; n = 0;
         end
      end while (!init_done && n < 20000);
      checks++; if (n !== 16385) begin failures++; $display("FAIL clr_restart_duration got=%0d want=16385", n); end
      drive(1'b1, 1'b0, 16'h0001, 16'h0); tick();
      checks++; if (rsp_rdata !== 16'h0) begin failures++; $display("FAIL clr_ignored_write got=%h want=0000", rsp_rdata); end
      drive(1'b0, 1'b0, 16'h0, 16'h0); tick();
   endtask
`endif

   initial begin
      test_reset();
      test_bank_isolation();
      test_pipelined();
      test_read_after_write();
      test_random();
      test_reset_pending();
`ifdef LC3_MEM_CLEAR_ON_RESET_EN
      test_clear_requests();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
